// File: rtl/ball_motion.sv
// ball_motion: serve packet -> CORDIC Cartesian velocity -> per-frame
// ball position with top/bottom reflection and left/right exit pulses.
module ball_motion #(
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int ITER  = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [21:0] location,
  input  logic [15:0] velocity,
  input  logic [16:0] angle,
  input  logic        frame_tick,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [15:0] vel_x,
  output logic [15:0] vel_y,
  output logic        busy,
  output logic        active,
  output logic        wall_bounce,
  output logic        out_left,
  output logic        out_right
);

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    SCALE,
    RUN
  } state_t;

  localparam logic signed [16:0] X_LO  = 17'(X_MIN * 16);
  localparam logic signed [16:0] X_HI  = 17'(X_MAX * 16);
  localparam logic signed [16:0] Y_LO  = 17'(Y_MIN * 16);
  localparam logic signed [16:0] Y_HI  = 17'(Y_MAX * 16);
  localparam logic signed [16:0] Y_LO2 = 17'(2 * Y_MIN * 16);
  localparam logic signed [16:0] Y_HI2 = 17'(2 * Y_MAX * 16);
  localparam logic signed [17:0] K_GAIN = 18'sd9949;

  // atan(2^-i) in units of pi*2^-15
  function automatic logic signed [17:0] atan_lut(
    input logic [3:0] i
  );
    case (i)
      4'd0:    atan_lut = 18'sd8192;
      4'd1:    atan_lut = 18'sd4836;
      4'd2:    atan_lut = 18'sd2555;
      4'd3:    atan_lut = 18'sd1297;
      4'd4:    atan_lut = 18'sd651;
      4'd5:    atan_lut = 18'sd326;
      4'd6:    atan_lut = 18'sd163;
      4'd7:    atan_lut = 18'sd81;
      4'd8:    atan_lut = 18'sd41;
      4'd9:    atan_lut = 18'sd20;
      4'd10:   atan_lut = 18'sd10;
      4'd11:   atan_lut = 18'sd5;
      4'd12:   atan_lut = 18'sd3;
      4'd13:   atan_lut = 18'sd1;
      4'd14:   atan_lut = 18'sd1;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic signed [17:0] cx_q, cx_d;
  logic signed [17:0] cy_q, cy_d;
  logic signed [17:0] cz_q, cz_d;
  logic signed [15:0] spd_q, spd_d;
  logic signed [15:0] px_q, px_d;
  logic signed [15:0] py_q, py_d;
  logic signed [15:0] vx_q, vx_d;
  logic signed [15:0] vy_q, vy_d;
  logic wall_q, wall_d;
  logic left_q, left_d;
  logic right_q, right_d;

  logic [15:0] mag;
  logic signed [17:0] z_mag;
  logic signed [17:0] z_init;
  logic signed [17:0] xs, ys;
  logic signed [31:0] prod_x, prod_y;
  logic signed [16:0] nx, ny;
  logic signed [16:0] ny_top, ny_bot;
  logic unused_bits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cz_d    = cz_q;
    spd_d   = spd_q;
    px_d    = px_q;
    py_d    = py_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    wall_d  = 1'b0;
    left_d  = 1'b0;
    right_d = 1'b0;

    mag    = (angle[15:0] > 16'd4096) ? 16'd4096 : angle[15:0];
    z_mag  = {mag, 2'b00};
    z_init = angle[16] ? -z_mag : z_mag;

    xs = cx_q >>> cnt_q;
    ys = cy_q >>> cnt_q;

    prod_x = 32'(spd_q) * 32'(cx_q);
    prod_y = 32'(spd_q) * 32'(cy_q);

    nx     = 17'(px_q) + 17'(vx_q);
    ny     = 17'(py_q) + 17'(vy_q);
    ny_top = Y_LO2 - ny;
    ny_bot = Y_HI2 - ny;

    if (load) begin
      state_d = ROTATE;
      cnt_d   = 4'd0;
      cx_d    = K_GAIN;
      cy_d    = 18'sd0;
      cz_d    = z_init;
      spd_d   = velocity;
      px_d    = {1'b0, location[21:11], 4'b0000};
      py_d    = {1'b0, location[10:0], 4'b0000};
    end else begin
      unique case (state_q)
        ROTATE: begin
          if (!cz_q[17]) begin
            cx_d = cx_q - ys;
            cy_d = cy_q + xs;
            cz_d = cz_q - atan_lut(cnt_q);
          end else begin
            cx_d = cx_q + ys;
            cy_d = cy_q - xs;
            cz_d = cz_q + atan_lut(cnt_q);
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(ITER - 1)) state_d = SCALE;
        end
        SCALE: begin
          vx_d    = prod_x[29:14];
          vy_d    = prod_y[29:14];
          state_d = RUN;
        end
        RUN: begin
          if (frame_tick) begin
            if (ny < Y_LO) begin
              py_d   = ny_top[15:0];
              vy_d   = -vy_q;
              wall_d = 1'b1;
            end else if (ny > Y_HI) begin
              py_d   = ny_bot[15:0];
              vy_d   = -vy_q;
              wall_d = 1'b1;
            end else begin
              py_d = ny[15:0];
            end
            if (nx < X_LO) begin
              px_d    = X_LO[15:0];
              left_d  = 1'b1;
              state_d = IDLE;
            end else if (nx > X_HI) begin
              px_d    = X_HI[15:0];
              right_d = 1'b1;
              state_d = IDLE;
            end else begin
              px_d = nx[15:0];
            end
          end
        end
        IDLE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign unused_bits = ^{prod_x[31:30], prod_x[13:0],
                         prod_y[31:30], prod_y[13:0],
                         ny_top[16], ny_bot[16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cz_q    <= '0;
      spd_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      wall_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cz_q    <= cz_d;
      spd_q   <= spd_d;
      px_q    <= px_d;
      py_q    <= py_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      wall_q  <= wall_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign ball_x      = px_q[14:4];
  assign ball_y      = py_q[14:4];
  assign vel_x       = vx_q;
  assign vel_y       = vy_q;
  assign busy        = (state_q == ROTATE) || (state_q == SCALE);
  assign active      = (state_q == RUN);
  assign wall_bounce = wall_q;
  assign out_left    = left_q;
  assign out_right   = right_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: behavioural model checked every cycle
// plus hand-computed literal expectations.
module tb_ball_motion;

  localparam int ITER = 14;
  localparam real PI = 3.14159265358979;

  logic        clk;
  logic        rst;
  logic        load;
  logic [21:0] location;
  logic [15:0] velocity;
  logic [16:0] angle;
  logic        frame_tick;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [15:0] vel_x;
  logic [15:0] vel_y;
  logic        busy;
  logic        active;
  logic        wall_bounce;
  logic        out_left;
  logic        out_right;

  ball_motion #(
    .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479), .ITER(ITER)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .location(location),
    .velocity(velocity), .angle(angle), .frame_tick(frame_tick),
    .ball_x(ball_x), .ball_y(ball_y), .vel_x(vel_x), .vel_y(vel_y),
    .busy(busy), .active(active), .wall_bounce(wall_bounce),
    .out_left(out_left), .out_right(out_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int atan_tab[16];

  int m_px, m_py, m_vx, m_vy, m_wait, p_vx, p_vy;
  bit m_busy, m_active, m_bnc, m_ol, m_or;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Bit-exact rotation-mode CORDIC followed by the scale multiply
  function automatic void cordic_vel(input int spd, input int mag_in,
                                     input bit neg,
                                     output int vx, output int vy);
    int x, y, z, mag, xs, ys, tx, ty;
    mag = (mag_in > 4096) ? 4096 : mag_in;
    x = 9949;
    y = 0;
    z = neg ? -4 * mag : 4 * mag;
    for (int i = 0; i < ITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - atan_tab[i];
      end else begin
        x = x + ys; y = y - xs; z = z + atan_tab[i];
      end
    end
    tx = (spd * x) >>> 14;
    ty = (spd * y) >>> 14;
    vx = int'(shortint'(tx));
    vy = int'(shortint'(ty));
  endfunction

  task automatic model_edge();
    int nx, ny;
    if (rst) begin
      m_px = 0; m_py = 0; m_vx = 0; m_vy = 0; m_wait = 0;
      m_busy = 0; m_active = 0; m_bnc = 0; m_ol = 0; m_or = 0;
    end else begin
      m_bnc = 0; m_ol = 0; m_or = 0;
      if (load) begin
        m_px = int'(location[21:11]) * 16;
        m_py = int'(location[10:0]) * 16;
        m_busy = 1; m_active = 0; m_wait = ITER + 1;
        cordic_vel(int'($signed(velocity)), int'(angle[15:0]),
                   angle[16], p_vx, p_vy);
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy = 0; m_active = 1; m_vx = p_vx; m_vy = p_vy;
        end
      end else if (m_active && frame_tick) begin
        nx = m_px + m_vx;
        ny = m_py + m_vy;
        if (ny < 0) begin
          m_py = -ny; m_vy = -m_vy; m_bnc = 1;
        end else if (ny > 479 * 16) begin
          m_py = 2 * 479 * 16 - ny; m_vy = -m_vy; m_bnc = 1;
        end else begin
          m_py = ny;
        end
        if (nx < 0) begin
          m_px = 0; m_ol = 1; m_active = 0;
        end else if (nx > 639 * 16) begin
          m_px = 639 * 16; m_or = 1; m_active = 0;
        end else begin
          m_px = nx;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_load(input logic [10:0] x, input logic [10:0] y,
                         input logic [15:0] v, input logic [16:0] a);
    location = {x, y};
    velocity = v;
    angle    = a;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_conv();
    int n = 0;
    while (!active && n < 50) begin
      step();
      n++;
    end
    chk("conv_done", int'(active), 1);
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(nm, n, ITER + 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("m_ball_x", int'(ball_x), (m_px >> 4) & 2047);
      chk("m_ball_y", int'(ball_y), (m_py >> 4) & 2047);
      chk("m_vel_x", int'($signed(vel_x)), m_vx);
      chk("m_vel_y", int'($signed(vel_y)), m_vy);
      chk("m_busy", int'(busy), int'(m_busy));
      chk("m_active", int'(active), int'(m_active));
      chk("m_bounce", int'(wall_bounce), int'(m_bnc));
      chk("m_left", int'(out_left), int'(m_ol));
      chk("m_right", int'(out_right), int'(m_or));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_x[7];
    int ex, ey;
    for (int i = 0; i < 16; i++)
      atan_tab[i] = $rtoi($atan(1.0 / real'(1 << i)) / PI * 32768.0 + 0.5);
    exp_x = '{430, 466, 502, 538, 574, 610, 639};

    rst = 1'b1; load = 1'b0; frame_tick = 1'b0;
    location = '0; velocity = '0; angle = '0;
    repeat (3) step();
    chk("rst_ball_x", int'(ball_x), 0);
    chk("rst_vel_x", int'(vel_x), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active", int'(active), 0);
    rst = 1'b0;
    step();

    // Serve to the right at angle 0
    do_load(11'd395, 11'd50, 16'h0240, 17'd0);
    chk("ld_ball_x", int'(ball_x), 395);
    chk("ld_ball_y", int'(ball_y), 50);
    count_busy("busy_len_a");
    chk("a_active", int'(active), 1);
    chk("a_vel_x", int'($signed(vel_x)), 575);
    chk("a_vel_y", int'($signed(vel_y)), 0);
    chk("a_vx_tol", int'(iabs(int'($signed(vel_x)) - 576) <= 2), 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("run_ball_x", int'(ball_x), exp_x[k]);
      chk("run_ball_y", int'(ball_y), 50);
      chk("run_right", int'(out_right), (k == 6) ? 1 : 0);
    end
    chk("exit_active", int'(active), 0);
    step();
    chk("right_once", int'(out_right), 0);
    tick();
    chk("idle_tick_x", int'(ball_x), 639);
    chk("idle_hold_vx", int'($signed(vel_x)), 575);

    // Straight up at -pi/2, tick ignored while converting
    do_load(11'd395, 11'd50, 16'h0240, {1'b1, 16'd4096});
    tick();
    chk("busy_tick_y", int'(ball_y), 50);
    wait_conv();
    chk("b_vel_y", int'($signed(vel_y)), -577);
    chk("b_vel_x", int'($signed(vel_x)), 0);
    tick();
    chk("b_y1", int'(ball_y), 13);
    chk("b_bnc1", int'(wall_bounce), 0);
    tick();
    chk("b_y2", int'(ball_y), 22);
    chk("b_bnc2", int'(wall_bounce), 1);
    chk("b_vy_pos", int'($signed(vel_y)), 577);
    step();
    chk("b_bnc_once", int'(wall_bounce), 0);

    // Over-range angle magnitude clamps to pi/2
    do_load(11'd200, 11'd200, 16'h0240, {1'b0, 16'd6000});
    wait_conv();
    cordic_vel(576, 4096, 1'b0, ex, ey);
    chk("clamp_vx", int'($signed(vel_x)), ex);
    chk("clamp_vy", int'($signed(vel_y)), ey);

    // Reload mid-rotation restarts with the new packet
    do_load(11'd395, 11'd50, 16'h0240, 17'd0);
    repeat (5) step();
    chk("mid_busy", int'(busy), 1);
    do_load(11'd100, 11'd200, 16'h0100, {1'b0, 16'd2048});
    count_busy("busy_len_b");
    cordic_vel(256, 2048, 1'b0, ex, ey);
    chk("re_vx", int'($signed(vel_x)), ex);
    chk("re_vy", int'($signed(vel_y)), ey);
    chk("re_cos_tol",
        int'(iabs(int'($signed(vel_x)) - $rtoi(256.0 * $cos(PI / 4.0) + 0.5)) <= 2), 1);
    tick();

    // Load and tick together: load wins
    frame_tick = 1'b1;
    do_load(11'd20, 11'd240, 16'hFF00, 17'd0);
    frame_tick = 1'b0;
    chk("ld_wins_x", int'(ball_x), 20);
    chk("ld_wins_busy", int'(busy), 1);
    wait_conv();
    chk("l_vel_x", int'($signed(vel_x)), -256);
    tick();
    chk("l_x1", int'(ball_x), 4);
    chk("l_left1", int'(out_left), 0);
    tick();
    chk("l_x2", int'(ball_x), 0);
    chk("l_left2", int'(out_left), 1);
    chk("l_active", int'(active), 0);

    // Bottom bounce and left exit on one tick
    do_load(11'd10, 11'd475, 16'hFE00, {1'b1, 16'd2048});
    wait_conv();
    tick();
    chk("both_left", int'(out_left), 1);
    chk("both_bnc", int'(wall_bounce), 1);
    chk("both_x", int'(ball_x), 0);

    // Reset during RUN
    do_load(11'd300, 11'd300, 16'h0100, 17'd0);
    wait_conv();
    tick();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_ball_x", int'(ball_x), 0);
    chk("r_ball_y", int'(ball_y), 0);
    chk("r_vel_x", int'(vel_x), 0);
    chk("r_vel_y", int'(vel_y), 0);
    chk("r_busy", int'(busy), 0);
    chk("r_active", int'(active), 0);
    chk("r_pulses", int'({wall_bounce, out_left, out_right}), 0);
    tick();
    chk("r_tick_x", int'(ball_x), 0);
    chk("r_tick_act", int'(active), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
